// File: rtl/keypad_scanner_pkg.sv
// Purpose: shared types, constants and helpers for the 4x4 keypad scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package keypad_scanner_pkg;

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        DEBOUNCE_P = 2'd1,
        HELD       = 2'd2,
        DEBOUNCE_R = 2'd3
    } kp_state_t;

    localparam int          NUM_ROWS = 4;
    localparam int          NUM_COLS = 4;
    // All columns released (pull-ups win); also the inactive row-strobe value.
    localparam logic [3:0]  ROW_IDLE = 4'b1111;

    // Active-low one-hot strobe for a row index.
    function automatic logic [3:0] row_strobe(input logic [1:0] idx);
        logic [3:0] r;
        r      = ROW_IDLE;
        r[idx] = 1'b0;
        return r;
    endfunction

    // Index of the lowest active-low column; lowest column wins on multi-press.
    function automatic logic [1:0] lowest_zero(input logic [3:0] v);
        logic [1:0] idx;
        if (!v[0])      idx = 2'd0;
        else if (!v[1]) idx = 2'd1;
        else if (!v[2]) idx = 2'd2;
        else            idx = 2'd3;
        return idx;
    endfunction

    // Phone-style layout:  1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D.
    // Digits map to 0..9; A..D map to A..D; '*' -> E, '#' -> F.
    function automatic logic [3:0] key_to_digit(input logic [3:0] code);
        logic [3:0] d;
        case (code)
            4'h0: d = 4'h1;  4'h1: d = 4'h2;  4'h2: d = 4'h3;  4'h3: d = 4'hA;
            4'h4: d = 4'h4;  4'h5: d = 4'h5;  4'h6: d = 4'h6;  4'h7: d = 4'hB;
            4'h8: d = 4'h7;  4'h9: d = 4'h8;  4'hA: d = 4'h9;  4'hB: d = 4'hC;
            4'hC: d = 4'hE;  4'hD: d = 4'h0;  4'hE: d = 4'hF;  default: d = 4'hD;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Purpose: WIDTH-bit two-flop synchronizer, async reset to all-ones (idle for active-low inputs).
// Latency: 2 clk cycles from d to q.
// Backpressure: none; free-running sampler.
// Ports: clk, rst (async active-high), d (raw async input), q (synchronized output).
module keypad_scanner_sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Purpose: scans a 4x4 active-low matrix keypad, debounces press/release, reports the key code.
// Latency: key_valid DEBOUNCE cycles after the detecting row sample; press-to-valid <= 2 + 4*ROW_DWELL + DEBOUNCE.
// Backpressure: none; key_valid is a one-cycle pulse, key_code holds until the next accepted key.
// Ports: clk, BTNR (async active-high reset), col_n (raw columns), row_n (row strobes),
//        key_code {row,col}, key_valid (accept pulse), key_down (held until release accepted).
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int ROW_DWELL = 4,   // >= 3: sync latency plus one settle cycle
    parameter int DEBOUNCE  = 20,  // >= 2
    parameter int CNT_W     = 5    // 2**CNT_W > max(ROW_DWELL, DEBOUNCE)
) (
    input  logic       clk,
    input  logic       BTNR,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(ROW_DWELL - 1);
    localparam logic [CNT_W-1:0] DEB_DONE   = CNT_W'(DEBOUNCE);

    logic [3:0]       col_s;
    kp_state_t        state;
    logic [1:0]       row_idx;
    logic [1:0]       col_idx;
    logic [3:0]       pattern;
    logic [CNT_W-1:0] dwell_cnt;
    logic [CNT_W-1:0] deb_cnt;

    keypad_scanner_sync2 #(.WIDTH(4)) u_col_sync (
        .clk (clk),
        .rst (BTNR),
        .d   (col_n),
        .q   (col_s)
    );

    always_ff @(posedge clk or posedge BTNR) begin
        if (BTNR) begin
            state     <= SCAN;
            row_idx   <= 2'd0;
            row_n     <= 4'b1110;
            col_idx   <= 2'd0;
            pattern   <= ROW_IDLE;
            dwell_cnt <= '0;
            deb_cnt   <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (dwell_cnt == DWELL_LAST) begin
                        dwell_cnt <= '0;
                        if (col_s != ROW_IDLE) begin
                            // Row stays driven while the candidate is debounced.
                            col_idx <= lowest_zero(col_s);
                            pattern <= col_s;
                            deb_cnt <= CNT_W'(1);
                            state   <= DEBOUNCE_P;
                        end else begin
                            row_idx <= row_idx + 2'd1;
                            row_n   <= row_strobe(row_idx + 2'd1);
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end

                DEBOUNCE_P: begin
                    if (deb_cnt == DEB_DONE) begin
                        key_code  <= {row_idx, col_idx};
                        key_valid <= 1'b1;
                        key_down  <= 1'b1;
                        deb_cnt   <= '0;
                        state     <= HELD;
                    end else if (col_s != pattern) begin
                        // Bounce: drop the candidate and carry on scanning at the next row.
                        row_idx   <= row_idx + 2'd1;
                        row_n     <= row_strobe(row_idx + 2'd1);
                        dwell_cnt <= '0;
                        deb_cnt   <= '0;
                        state     <= SCAN;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end

                HELD: begin
                    // Pattern changes other than a full release are ignored.
                    if (col_s == ROW_IDLE) begin
                        deb_cnt <= CNT_W'(1);
                        state   <= DEBOUNCE_R;
                    end else begin
                        deb_cnt <= '0;
                    end
                end

                DEBOUNCE_R: begin
                    if (deb_cnt == DEB_DONE) begin
                        key_down  <= 1'b0;
                        row_idx   <= 2'd0;
                        row_n     <= 4'b1110;
                        dwell_cnt <= '0;
                        deb_cnt   <= '0;
                        state     <= SCAN;
                    end else if (col_s != ROW_IDLE) begin
                        deb_cnt <= '0;
                        state   <= HELD;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Purpose: directed bench for keypad_scanner with a behavioural 4x4 key matrix.
// Latency: cycle numbers count posedges after reset release (P1, P2, ...).
// Backpressure: n/a.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        BTNR;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] keys;     // bit r*4+c set = key at row r, column c pressed

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int kv_count = 0;
    int kv_cyc = -1;
    logic [3:0] kv_code = 4'h0;
    int viol = 0;
    logic prev_kv = 1'b0;
    logic prev_kd = 1'b0;

    always #5 clk = ~clk;

    // Key matrix: a pressed key pulls its column low while its row is strobed.
    always_comb begin
        col_n = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
    end

    keypad_scanner #(.ROW_DWELL(4), .DEBOUNCE(20), .CNT_W(5)) dut (
        .clk       (clk),
        .BTNR      (BTNR),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    typedef struct {
        logic [15:0] keys;
        logic [3:0]  row_n;
        logic        kv;
        logic        kd;
        logic [3:0]  code;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (key_valid) begin
            kv_count++;
            kv_cyc  = cyc;
            kv_code = key_code;
            if (prev_kv || prev_kd) viol++;
        end
        prev_kv = key_valid;
        prev_kd = key_down;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset(input logic [15:0] k);
        keys = k;
        BTNR = 1'b1;
        #1;
        check("async_rst_row_n", row_n, 4'b1110);
        check("async_rst_outs", {key_valid, key_down, key_code}, 6'd0);
        repeat (3) tick();
        check("rst_row_n", row_n, 4'b1110);
        check("rst_outs", {key_valid, key_down, key_code}, 6'd0);
        BTNR     = 1'b0;
        cyc      = 0;
        kv_count = 0;
        kv_cyc   = -1;
        prev_kv  = 1'b0;
        prev_kd  = 1'b0;
    endtask

    initial begin
        // Idle scan: rows step every 4 cycles, first step at P4.
        for (int i = 0; i < 16; i++) begin
            tbl[i].keys = 16'h0;
            tbl[i].kv   = 1'b0;
            tbl[i].kd   = 1'b0;
            tbl[i].code = 4'h0;
        end
        tbl[0].row_n  = 4'b1110; tbl[1].row_n  = 4'b1110; tbl[2].row_n  = 4'b1110;
        tbl[3].row_n  = 4'b1101; tbl[4].row_n  = 4'b1101; tbl[5].row_n  = 4'b1101;
        tbl[6].row_n  = 4'b1101; tbl[7].row_n  = 4'b1011; tbl[8].row_n  = 4'b1011;
        tbl[9].row_n  = 4'b1011; tbl[10].row_n = 4'b1011; tbl[11].row_n = 4'b0111;
        tbl[12].row_n = 4'b0111; tbl[13].row_n = 4'b0111; tbl[14].row_n = 4'b0111;
        tbl[15].row_n = 4'b1110;

        keys = 16'h0;
        BTNR = 1'b0;
        @(negedge clk);

        // 1. Reset and idle scanning.
        do_reset(16'h0);
        for (int i = 0; i < 16; i++) begin
            keys = tbl[i].keys;
            tick();
            check($sformatf("scan_vec%0d", i + 1), {row_n, key_valid, key_down, key_code},
                  {tbl[i].row_n, tbl[i].kv, tbl[i].kd, tbl[i].code});
        end

        // 2. Clean press of key 9 (row 2, col 1): detect at P12, accept at P32.
        do_reset(16'h0200);
        run_to(31);
        check("k9_no_early_valid", kv_count, 0);
        run_to(32);
        check("k9_valid_pulse", {key_valid, key_down, key_code}, {1'b1, 1'b1, 4'h9});
        run_to(60);
        check("k9_one_valid", kv_count, 1);
        check("k9_valid_cycle", kv_cyc, 32);
        check("k9_held", {key_down, row_n}, {1'b1, 4'b1011});
        keys = 16'h0;                          // release seen by FSM at P63
        run_to(82);
        check("k9_down_before_rel", key_down, 1'b1);
        run_to(83);
        check("k9_released", {key_down, row_n}, {1'b0, 4'b1110});
        check("k9_code_held", key_code, 4'h9);

        // 3. Press bounce on row 2: candidate dropped at P16, scan resumes at row 3.
        do_reset(16'h0);
        run_to(8);
        keys = 16'h0200;
        run_to(13);
        keys = 16'h0;
        run_to(15);
        check("bounce_row_frozen", row_n, 4'b1011);
        run_to(16);
        check("bounce_row3", row_n, 4'b0111);
        run_to(19);
        check("bounce_row3_dwell", row_n, 4'b0111);
        run_to(20);
        check("bounce_row0", row_n, 4'b1110);
        run_to(50);
        check("bounce_no_valid", {kv_count[7:0], key_down}, 9'd0);

        // 4. Two keys in row 0 (cols 1, 3): lowest column wins, accept at P24.
        do_reset(16'h000A);
        run_to(23);
        check("two_keys_no_early", kv_count, 0);
        run_to(24);
        check("two_keys_valid", {key_valid, key_down, key_code}, {1'b1, 1'b1, 4'h1});
        run_to(25);
        check("two_keys_pulse_end", key_valid, 1'b0);

        // 5. Release bounce: release at P30, re-press P40..P42, final release; key_down falls at P65.
        run_to(30);
        keys = 16'h0;
        run_to(40);
        keys = 16'h000A;
        run_to(42);
        keys = 16'h0;
        run_to(64);
        check("relb_still_down", key_down, 1'b1);
        run_to(65);
        check("relb_released", {key_down, row_n}, {1'b0, 4'b1110});
        check("relb_one_valid", kv_count, 1);

        // 6. Long hold of key F (row 3, col 3): accept at P36, then reset mid-hold.
        do_reset(16'h8000);
        run_to(1040);
        check("kf_one_valid", kv_count, 1);
        check("kf_valid_cycle", kv_cyc, 36);
        check("kf_code", {key_down, kv_code}, {1'b1, 4'hF});
        do_reset(16'h8000);
        run_to(60);
        check("kf_redetect_count", kv_count, 1);
        check("kf_redetect_cycle", kv_cyc, 36);
        check("kf_redetect_code", kv_code, 4'hF);

        check("valid_protocol", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
